i2c_master: RTL and testbench

- Single-byte I2C controller (initiator). It is the far end of the bus from the I2C slave RTL.
- Accepts a command of 7-bit address, R/W and data byte on a valid/ready interface. Generates START, address, data and STOP on open-drain scl/sda, then returns one response.
- Used as the bus driver in the slave test bench and as a reusable controller in system RTL.

---
 rtl/i2c_master.sv | 176 +++++++++++++++++
 tb/tb_i2c_master.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C initiator driving open-drain scl/sda from a valid/ready command.
// Optional: define I2C_CLK_STRETCH_EN to honour slave clock stretching on released scl quarters.

module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       busy,
    inout  wire        scl,
    inout  wire        sda
);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, STOP, DONE
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'(CLK_DIV - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [1:0]  quarter;
    logic [2:0]  bit_cnt;
    logic [7:0]  tx;
    logic [7:0]  rx;
    logic [7:0]  data_reg;
    logic        rw;
    logic        scl_low;
    logic        sda_low;
    logic        sample_done;
    logic        sda_in;
    logic        hold;
    logic        tick;
    logic        sample;

    assign scl    = scl_low ? 1'b0 : 1'bz;
    assign sda    = sda_low ? 1'b0 : 1'bz;
    assign sda_in = sda;

`ifdef I2C_CLK_STRETCH_EN
    logic stretch_phase;
    assign stretch_phase = ((state inside {ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK}) && quarter[1])
                         || (state == STOP && quarter != 2'd0);
    // Only a slave holding scl low after we have actually released it counts as stretching.
    assign hold = stretch_phase && !scl_low && !scl;
`else
    assign hold = 1'b0;
`endif

    assign tick   = !hold && (cnt == CNT_MAX);
    assign sample = (quarter == 2'd3) && !sample_done && !hold;

    // Bus levels {scl_low, sda_low} for a given phase; registered one clock behind the phase.
    function automatic logic [1:0] bus_levels(input state_t s, input logic [1:0] q, input logic bit_out);
        case (s)
            START:                        return {1'b0, q[1]};
            ADDR, WDATA:                  return {!q[1], !bit_out};
            ADDR_ACK, WACK, RDATA, RACK:  return {!q[1], 1'b0};
            STOP:                         return {q == 2'd0, q != 2'd3};
            default:                      return 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            quarter     <= '0;
            bit_cnt     <= '0;
            tx          <= '0;
            rx          <= '0;
            data_reg    <= '0;
            rw          <= 1'b0;
            scl_low     <= 1'b0;
            sda_low     <= 1'b0;
            sample_done <= 1'b0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_nack    <= 1'b0;
        end else begin
            {scl_low, sda_low} <= bus_levels(state, quarter, tx[7]);
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        tx          <= {cmd_addr, cmd_rw};
                        rw          <= cmd_rw;
                        data_reg    <= cmd_data;
                        rx          <= '0;
                        rsp_data    <= '0;
                        rsp_nack    <= 1'b0;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        cnt         <= '0;
                        quarter     <= '0;
                        sample_done <= 1'b0;
                        state       <= START;
                    end
                end
                DONE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    cnt <= (hold || tick) ? 16'd0 : cnt + 16'd1;
                    if (sample) begin
                        sample_done <= 1'b1;
                        case (state)
                            ADDR_ACK: rsp_nack <= sda_in;
                            WACK:     if (sda_in) rsp_nack <= 1'b1;
                            RDATA:    rx <= {rx[6:0], sda_in};
                            default:  ;
                        endcase
                    end
                    if (tick) begin
                        quarter     <= quarter + 2'd1;
                        sample_done <= 1'b0;
                        // Phase changes happen only at the end of the fourth quarter.
                        if (quarter == 2'd3) begin
                            case (state)
                                START: begin
                                    bit_cnt <= 3'd7;
                                    state   <= ADDR;
                                end
                                ADDR, WDATA: begin
                                    if (bit_cnt == 3'd0)
                                        state <= (state == ADDR) ? ADDR_ACK : WACK;
                                    else begin
                                        bit_cnt <= bit_cnt - 3'd1;
                                        tx      <= {tx[6:0], 1'b0};
                                    end
                                end
                                ADDR_ACK: begin
                                    bit_cnt <= 3'd7;
                                    if (rsp_nack)
                                        state <= STOP;
                                    else if (rw)
                                        state <= RDATA;
                                    else begin
                                        tx    <= data_reg;
                                        state <= WDATA;
                                    end
                                end
                                RDATA: begin
                                    if (bit_cnt == 3'd0)
                                        state <= RACK;
                                    else
                                        bit_cnt <= bit_cnt - 3'd1;
                                end
                                WACK, RACK: state <= STOP;
                                STOP: begin
                                    rsp_valid <= 1'b1;
                                    rsp_data  <= rw ? rx : 8'h00;
                                    state     <= DONE;
                                end
                                default: state <= IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed bench with a behavioural I2C slave and a response scoreboard.
// Build with I2C_CLK_STRETCH_EN to add the clock-stretching scenario.

module tb_i2c_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_data = '0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_nack;
    logic       busy;
    wire        scl_w;
    wire        sda_w;

    pullup (scl_w);
    pullup (sda_w);

    logic slv_sda_low = 1'b0;
    logic slv_scl_low = 1'b0;
    assign sda_w = slv_sda_low ? 1'b0 : 1'bz;
    assign scl_w = slv_scl_low ? 1'b0 : 1'bz;

    i2c_master #(.CLK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_rw    (cmd_rw),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_nack  (rsp_nack),
        .busy      (busy),
        .scl       (scl_w),
        .sda       (sda_w)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       nack;
        int         lat;
        bit         exact;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         t0 = 0;
    int         hs_count = 0;
    int         ready_viol = 0;

    // Slave model state
    logic [6:0] slave_addr = 7'h50;
    logic [7:0] slave_tx = 8'h3C;
    logic [7:0] rx_bytes[$];
    int         stop_count = 0;
    logic       master_ack_bit = 1'b0;
    int         sphase = 0;
    int         bitn = 0;
    logic [7:0] sh = '0;
    logic       srw = 1'b0;
    logic       s_prev = 1'b1;
    logic       d_prev = 1'b1;
    bit         stretch_en = 1'b0;
    int         stretch_cnt = 0;
    bit         ignore_rise = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int byte_at(input int i);
        if (i < rx_bytes.size()) return int'(rx_bytes[i]);
        return -1;
    endfunction

    // Push the expected response, then drive the command until it is accepted.
    task automatic applyStimulus(input logic [6:0] a, input logic rw, input logic [7:0] d,
                                 input logic [7:0] exp_data, input logic exp_nack,
                                 input int exp_lat, input bit exact, input bit push);
        int hs0;
        bit got;
        exp_t e;
        if (push) begin
            e.data = exp_data; e.nack = exp_nack; e.lat = exp_lat; e.exact = exact;
            exp_q.push_back(e);
        end
        hs0 = hs_count;
        got = 1'b0;
        @(posedge clk); #1;
        cmd_addr = a; cmd_rw = rw; cmd_data = d; cmd_valid = 1'b1;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(posedge clk);
            if (hs_count != hs0) got = 1'b1;
        end
        #1 cmd_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("[TB] FAIL handshake_timeout: got no handshake, expected one");
        end
    endtask

    task automatic waitIdle(input int bound);
        bit done;
        done = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < bound && !done; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && !busy && cmd_ready) done = 1'b1;
        end
        if (!done) begin
            checks++; errors++;
            $display("[TB] FAIL idle_timeout: pending=%0d, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
    endtask

    // Monitor: counts handshakes, timestamps captures and scores every response pulse.
    always @(negedge clk) begin
        exp_t e;
        int lat;
        cyc++;
        if (!rst) begin
            if (cmd_valid && cmd_ready) begin
                t0 = cyc;
                hs_count++;
            end
            if (busy && cmd_ready) ready_viol++;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_rsp: got rsp_valid, expected none");
                end else begin
                    e = exp_q.pop_front();
                    lat = cyc - t0;
                    checkOutput("rsp_data", int'(rsp_data), int'(e.data));
                    checkOutput("rsp_nack", int'(rsp_nack), int'(e.nack));
                    if (e.exact)
                        checkOutput("latency", lat, e.lat);
                    else begin
                        checks++;
                        if (lat < e.lat) begin
                            errors++;
                            $display("[TB] FAIL latency_min: got %0d, expected >= %0d", lat, e.lat);
                        end
                    end
                end
            end
        end
    end

    // Behavioural slave: reacts to scl edges seen at the falling clock edge.
    always @(negedge clk) begin
        logic s, d;
        s = scl_w;
        d = sda_w;
        if (stretch_cnt > 0) begin
            stretch_cnt--;
            if (stretch_cnt == 0) begin
                slv_scl_low = 1'b0;
                ignore_rise = 1'b1;
            end
        end
        if (s_prev && s && d_prev && !d) begin
            sphase = 1; bitn = 0; sh = '0; slv_sda_low = 1'b0;
        end else if (s_prev && s && !d_prev && d) begin
            stop_count++; sphase = 0; slv_sda_low = 1'b0;
        end else if (!s_prev && s) begin
            if (ignore_rise)
                ignore_rise = 1'b0;
            else begin
                case (sphase)
                    1, 3: begin
                        sh = {sh[6:0], d};
                        bitn++;
                        if (sphase == 1 && bitn == 8 && stretch_en) begin
                            slv_scl_low = 1'b1;
                            stretch_cnt = 50;
                        end
                    end
                    5: bitn++;
                    6: master_ack_bit = d;
                    default: ;
                endcase
            end
        end else if (s_prev && !s && !slv_scl_low) begin
            case (sphase)
                1: if (bitn == 8) begin
                    rx_bytes.push_back(sh);
                    if (sh[7:1] == slave_addr) begin
                        srw = sh[0]; slv_sda_low = 1'b1; sphase = 2;
                    end else
                        sphase = 0;
                end
                2: begin
                    bitn = 0;
                    if (srw) begin
                        sphase = 5; slv_sda_low = !slave_tx[7];
                    end else begin
                        sphase = 3; sh = '0; slv_sda_low = 1'b0;
                    end
                end
                3: if (bitn == 8) begin
                    rx_bytes.push_back(sh); slv_sda_low = 1'b1; sphase = 4;
                end
                4: begin
                    slv_sda_low = 1'b0; sphase = 0;
                end
                5: begin
                    if (bitn == 8) begin
                        slv_sda_low = 1'b0; sphase = 6;
                    end else
                        slv_sda_low = !slave_tx[7 - bitn];
                end
                6: sphase = 0;
                default: ;
            endcase
        end
        s_prev = s;
        d_prev = d;
    end

    initial begin
        int stop0;
        int hs0;
        bit got;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_cmd_ready", int'(cmd_ready), 1);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
        checkOutput("reset_rsp_data", int'(rsp_data), 0);
        checkOutput("reset_rsp_nack", int'(rsp_nack), 0);
        checkOutput("reset_scl", int'(scl_w), 1);
        checkOutput("reset_sda", int'(sda_w), 1);
        @(posedge clk); #1 rst = 1'b0;

        $display("[TB] write 0x50 <- 0xA5");
        rx_bytes.delete(); stop0 = stop_count;
        applyStimulus(7'h50, 1'b0, 8'hA5, 8'h00, 1'b0, 321, 1'b1, 1'b1);
        waitIdle(3000);
        checkOutput("wr_nbytes", rx_bytes.size(), 2);
        checkOutput("wr_addr_byte", byte_at(0), 'hA0);
        checkOutput("wr_data_byte", byte_at(1), 'hA5);
        checkOutput("wr_stop", stop_count - stop0, 1);

        $display("[TB] read 0x50 -> 0x3C");
        rx_bytes.delete(); stop0 = stop_count; master_ack_bit = 1'b0;
        applyStimulus(7'h50, 1'b1, 8'hFF, 8'h3C, 1'b0, 321, 1'b1, 1'b1);
        waitIdle(3000);
        checkOutput("rd_nbytes", rx_bytes.size(), 1);
        checkOutput("rd_addr_byte", byte_at(0), 'hA1);
        checkOutput("rd_master_nack", int'(master_ack_bit), 1);
        checkOutput("rd_stop", stop_count - stop0, 1);

        $display("[TB] address NACK at 0x23");
        rx_bytes.delete(); stop0 = stop_count;
        applyStimulus(7'h23, 1'b0, 8'h77, 8'h00, 1'b1, 177, 1'b1, 1'b1);
        waitIdle(3000);
        checkOutput("nack_nbytes", rx_bytes.size(), 1);
        checkOutput("nack_addr_byte", byte_at(0), 'h46);
        checkOutput("nack_stop", stop_count - stop0, 1);

        $display("[TB] reset during WDATA bit 3");
        applyStimulus(7'h50, 1'b0, 8'hA5, 8'h00, 1'b0, 0, 1'b1, 1'b0);
        repeat (230) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_scl", int'(scl_w), 1);
        checkOutput("abort_sda", int'(sda_w), 1);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_cmd_ready", int'(cmd_ready), 1);
        checkOutput("abort_rsp_valid", int'(rsp_valid), 0);
        repeat (4) @(posedge clk);
        rx_bytes.delete();
        applyStimulus(7'h50, 1'b0, 8'h5A, 8'h00, 1'b0, 321, 1'b1, 1'b1);
        waitIdle(3000);
        checkOutput("post_abort_data_byte", byte_at(1), 'h5A);

        $display("[TB] cmd_valid held across two commands");
        rx_bytes.delete(); hs0 = hs_count; ready_viol = 0;
        exp_q.push_back('{data: 8'h00, nack: 1'b0, lat: 321, exact: 1'b1});
        exp_q.push_back('{data: 8'h3C, nack: 1'b0, lat: 321, exact: 1'b1});
        @(posedge clk); #1;
        cmd_addr = 7'h50; cmd_rw = 1'b0; cmd_data = 8'h11; cmd_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(posedge clk);
            if (hs_count == hs0 + 1) got = 1'b1;
        end
        #1 cmd_rw = 1'b1; cmd_data = 8'hEE;
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(posedge clk);
            if (hs_count == hs0 + 2) got = 1'b1;
        end
        #1 cmd_valid = 1'b0;
        waitIdle(3000);
        checkOutput("held_handshakes", hs_count - hs0, 2);
        checkOutput("held_ready_while_busy", ready_viol, 0);
        checkOutput("held_first_data_byte", byte_at(1), 'h11);
        checkOutput("held_second_addr_byte", byte_at(2), 'hA1);

`ifdef I2C_CLK_STRETCH_EN
        $display("[TB] write with slave clock stretch");
        rx_bytes.delete();
        stretch_en = 1'b1;
        applyStimulus(7'h50, 1'b0, 8'hA5, 8'h00, 1'b0, 371, 1'b0, 1'b1);
        waitIdle(3000);
        stretch_en = 1'b0;
        checkOutput("stretch_addr_byte", byte_at(0), 'hA0);
        checkOutput("stretch_data_byte", byte_at(1), 'hA5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] global timeout");
    end

endmodule
